// File: rtl/mem_port_arbiter.sv
// Round-robin I/D port arbiter in front of a run-length-compressed memory port.
// Loads are expanded into a block buffer and streamed out; stores forward one word.
module mem_port_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int MAX_WAIT    = 255
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           REQ_I,
  input  logic                           REQ_D,
  input  logic                           WE_I,
  input  logic                           WE_D,
  input  logic [31:0]                    ADDR_I,
  input  logic [31:0]                    ADDR_D,
  input  logic [31:0]                    WDATA_I,
  input  logic [31:0]                    WDATA_D,
  output logic                           GNT_I,
  output logic                           GNT_D,
  output logic                           RVALID_I,
  output logic                           RVALID_D,
  output logic [$clog2(BLOCK_WORDS)-1:0] RIDX,
  output logic [31:0]                    RDATA,
  output logic                           DONE_I,
  output logic                           DONE_D,
  output logic                           ERR,
  output logic                           MEM_VALID,
  output logic                           MEM_LOAD,
  output logic                           MEM_STORE,
  output logic [31:0]                    MEM_ADDR,
  output logic [31:0]                    MEM_WDATA,
  input  logic                           MEM_READY,
  input  logic                           MEM_RUN_VALID,
  input  logic [31:0]                    MEM_RUN_BASE,
  input  logic [3:0]                     MEM_RUN_LEN,
  output logic                           MEM_RUN_ACK,
  input  logic                           MEM_WACK
);

  localparam int IW = $clog2(BLOCK_WORDS);
  localparam int CW = 6;
  localparam int WW = $clog2(MAX_WAIT + 1) + 1;
  localparam logic [31:0]   ALIGN_MASK = ~(32'(BLOCK_WORDS) - 32'd1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(BLOCK_WORDS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_RUNS   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;

  logic [2:0]    state_r;
  logic          last_d_r, port_d_r;
  logic          gnt_i_r, gnt_d_r, rvalid_i_r, rvalid_d_r, done_i_r, done_d_r, err_r;
  logic          mem_valid_r, mem_load_r, mem_store_r;
  logic [31:0]   mem_addr_r, mem_wdata_r, rdata_r;
  logic [IW-1:0] ridx_r;
  logic [CW-1:0] fp_r;
  logic [WW-1:0] wcnt_r;
  logic [31:0]   buf_r      [BLOCK_WORDS];
  logic [31:0]   buf_next_s [BLOCK_WORDS];

  logic          win_d_s, sel_we_s, run_fire_s, clip_s;
  logic [31:0]   sel_addr_s, sel_wdata_s;
  logic [CW-1:0] room_s, len_ext_s, len_eff_s, fp_end_s;
  logic [IW-1:0] ridx_nxt_s;

  assign run_fire_s  = MEM_RUN_VALID && (state_r == S_RUNS);
  assign MEM_RUN_ACK = run_fire_s;
  assign ridx_nxt_s  = ridx_r + IW'(1);

  // Winner selection: a tie goes to the port that was not granted last
  always_comb begin
    win_d_s = REQ_D && (!REQ_I || !last_d_r);
    if (win_d_s) begin
      sel_we_s    = WE_D;
      sel_addr_s  = ADDR_D;
      sel_wdata_s = WDATA_D;
    end else begin
      sel_we_s    = WE_I;
      sel_addr_s  = ADDR_I;
      sel_wdata_s = WDATA_I;
    end
  end

  // Run expansion: clip the run to the space left and compute the post-write buffer
  always_comb begin
    room_s    = CW'(BLOCK_WORDS) - fp_r;
    len_ext_s = CW'(MEM_RUN_LEN);
    clip_s    = len_ext_s > room_s;
    if (clip_s) begin
      len_eff_s = room_s;
    end else begin
      len_eff_s = len_ext_s;
    end
    fp_end_s = fp_r + len_eff_s;
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      if (run_fire_s && (CW'(k) >= fp_r) && (CW'(k) < fp_end_s)) begin
        buf_next_s[k] = MEM_RUN_BASE;
      end else begin
        buf_next_s[k] = buf_r[k];
      end
    end
  end

  // Block buffer storage; intentionally survives reset
  always_ff @(posedge CLK) begin
    buf_r <= buf_next_s;
  end

  // Control FSM and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= S_IDLE;
      last_d_r    <= 1'b1;
      port_d_r    <= 1'b0;
      gnt_i_r     <= 1'b0;
      gnt_d_r     <= 1'b0;
      rvalid_i_r  <= 1'b0;
      rvalid_d_r  <= 1'b0;
      done_i_r    <= 1'b0;
      done_d_r    <= 1'b0;
      err_r       <= 1'b0;
      mem_valid_r <= 1'b0;
      mem_load_r  <= 1'b0;
      mem_store_r <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      rdata_r     <= 32'd0;
      ridx_r      <= '0;
      fp_r        <= '0;
      wcnt_r      <= '0;
    end else begin
      gnt_i_r  <= 1'b0;
      gnt_d_r  <= 1'b0;
      done_i_r <= 1'b0;
      done_d_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          wcnt_r <= '0;
          if (REQ_I || REQ_D) begin
            port_d_r    <= win_d_s;
            last_d_r    <= win_d_s;
            gnt_i_r     <= !win_d_s;
            gnt_d_r     <= win_d_s;
            mem_valid_r <= 1'b1;
            mem_load_r  <= !sel_we_s;
            mem_store_r <= sel_we_s;
            mem_addr_r  <= sel_we_s ? sel_addr_s : (sel_addr_s & ALIGN_MASK);
            mem_wdata_r <= sel_we_s ? sel_wdata_s : 32'd0;
            state_r     <= S_CMD;
          end
        end
        S_CMD: begin
          if (mem_valid_r && MEM_READY) begin
            mem_valid_r <= 1'b0;
            mem_load_r  <= 1'b0;
            mem_store_r <= 1'b0;
            wcnt_r      <= '0;
            fp_r        <= '0;
            state_r     <= mem_store_r ? S_WRITE : S_RUNS;
          end else if (wcnt_r == WAIT_LAST) begin
            mem_valid_r <= 1'b0;
            mem_load_r  <= 1'b0;
            mem_store_r <= 1'b0;
            err_r       <= 1'b1;
            done_i_r    <= !port_d_r;
            done_d_r    <= port_d_r;
            wcnt_r      <= '0;
            state_r     <= S_IDLE;
          end else begin
            wcnt_r <= wcnt_r + WW'(1);
          end
        end
        S_RUNS: begin
          if (run_fire_s) begin
            wcnt_r <= '0;
            if ((MEM_RUN_LEN == 4'd0) || clip_s) begin
              err_r <= 1'b1;
            end
            if (fp_end_s == CW'(BLOCK_WORDS)) begin
              fp_r       <= '0;
              ridx_r     <= '0;
              rdata_r    <= buf_next_s[0];
              rvalid_i_r <= !port_d_r;
              rvalid_d_r <= port_d_r;
              state_r    <= S_STREAM;
            end else begin
              fp_r <= fp_end_s;
            end
          end else if (wcnt_r == WAIT_LAST) begin
            err_r    <= 1'b1;
            done_i_r <= !port_d_r;
            done_d_r <= port_d_r;
            wcnt_r   <= '0;
            fp_r     <= '0;
            state_r  <= S_IDLE;
          end else begin
            wcnt_r <= wcnt_r + WW'(1);
          end
        end
        S_STREAM: begin
          if (ridx_r == IDX_LAST) begin
            rvalid_i_r <= 1'b0;
            rvalid_d_r <= 1'b0;
            ridx_r     <= '0;
            rdata_r    <= 32'd0;
            state_r    <= S_IDLE;
          end else begin
            ridx_r  <= ridx_nxt_s;
            rdata_r <= buf_r[ridx_nxt_s];
            if (ridx_nxt_s == IDX_LAST) begin
              done_i_r <= !port_d_r;
              done_d_r <= port_d_r;
            end
          end
        end
        S_WRITE: begin
          // DONE is already showing the acknowledge; leave on the following edge
          if (done_i_r || done_d_r) begin
            wcnt_r  <= '0;
            state_r <= S_IDLE;
          end else if (MEM_WACK) begin
            done_i_r <= !port_d_r;
            done_d_r <= port_d_r;
          end else if (wcnt_r == WAIT_LAST) begin
            err_r    <= 1'b1;
            done_i_r <= !port_d_r;
            done_d_r <= port_d_r;
            wcnt_r   <= '0;
            state_r  <= S_IDLE;
          end else begin
            wcnt_r <= wcnt_r + WW'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign GNT_I     = gnt_i_r;
  assign GNT_D     = gnt_d_r;
  assign RVALID_I  = rvalid_i_r;
  assign RVALID_D  = rvalid_d_r;
  assign RIDX      = ridx_r;
  assign RDATA     = rdata_r;
  assign DONE_I    = done_i_r;
  assign DONE_D    = done_d_r;
  assign ERR       = err_r;
  assign MEM_VALID = mem_valid_r;
  assign MEM_LOAD  = mem_load_r;
  assign MEM_STORE = mem_store_r;
  assign MEM_ADDR  = mem_addr_r;
  assign MEM_WDATA = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: loads, stores, arbitration, run errors,
// timeout and reset, with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        CLK, RESET;
  logic        REQ_I, REQ_D, WE_I, WE_D;
  logic [31:0] ADDR_I, ADDR_D, WDATA_I, WDATA_D;
  logic        GNT_I, GNT_D, RVALID_I, RVALID_D, DONE_I, DONE_D, ERR;
  logic [2:0]  RIDX;
  logic [31:0] RDATA;
  logic        MEM_VALID, MEM_LOAD, MEM_STORE;
  logic [31:0] MEM_ADDR, MEM_WDATA;
  logic        MEM_READY, MEM_RUN_VALID, MEM_RUN_ACK, MEM_WACK;
  logic [31:0] MEM_RUN_BASE;
  logic [3:0]  MEM_RUN_LEN;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  mem_port_arbiter #(.BLOCK_WORDS(8), .MAX_WAIT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_I(REQ_I), .REQ_D(REQ_D), .WE_I(WE_I), .WE_D(WE_D),
    .ADDR_I(ADDR_I), .ADDR_D(ADDR_D), .WDATA_I(WDATA_I), .WDATA_D(WDATA_D),
    .GNT_I(GNT_I), .GNT_D(GNT_D), .RVALID_I(RVALID_I), .RVALID_D(RVALID_D),
    .RIDX(RIDX), .RDATA(RDATA), .DONE_I(DONE_I), .DONE_D(DONE_D), .ERR(ERR),
    .MEM_VALID(MEM_VALID), .MEM_LOAD(MEM_LOAD), .MEM_STORE(MEM_STORE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_READY(MEM_READY),
    .MEM_RUN_VALID(MEM_RUN_VALID), .MEM_RUN_BASE(MEM_RUN_BASE),
    .MEM_RUN_LEN(MEM_RUN_LEN), .MEM_RUN_ACK(MEM_RUN_ACK), .MEM_WACK(MEM_WACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; outputs are then observed 1 time unit after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    vec_cnt++;
    if ({GNT_I, GNT_D, RVALID_I, RVALID_D, DONE_I, DONE_D, ERR, MEM_VALID, MEM_LOAD, MEM_STORE, MEM_RUN_ACK} !== 11'd0) begin
      miss_cnt++;
      $display("FAIL reset_flags: got %b want 0", {GNT_I, GNT_D, RVALID_I, RVALID_D, DONE_I, DONE_D, ERR, MEM_VALID, MEM_LOAD, MEM_STORE, MEM_RUN_ACK});
    end
    vec_cnt++;
    if ({RIDX, RDATA, MEM_ADDR, MEM_WDATA} !== 99'd0) begin
      miss_cnt++;
      $display("FAIL reset_buses: got ridx=%0d rdata=%h addr=%h wdata=%h want 0", RIDX, RDATA, MEM_ADDR, MEM_WDATA);
    end
    RESET = 1'b0;
  endtask

  task automatic test_tie_rr();
    logic [1:0]  exp_g;
    logic [31:0] exp_a;
    REQ_I = 1'b1; REQ_D = 1'b1; WE_I = 1'b0; WE_D = 1'b0;
    ADDR_I = 32'h0000_0104; ADDR_D = 32'h0000_020B;
    for (int n = 0; n < 4; n++) begin
      exp_g = (n[0] == 1'b0) ? 2'b10 : 2'b01;
      exp_a = (n[0] == 1'b0) ? 32'h0000_0100 : 32'h0000_0208;
      tick();
      vec_cnt++;
      if ({GNT_I, GNT_D} !== exp_g) begin
        miss_cnt++;
        $display("FAIL tie_grant n=%0d: got %b want %b", n, {GNT_I, GNT_D}, exp_g);
      end
      vec_cnt++;
      if (MEM_ADDR !== exp_a) begin
        miss_cnt++;
        $display("FAIL tie_addr n=%0d: got %h want %h", n, MEM_ADDR, exp_a);
      end
      MEM_READY = 1'b1;
      tick();
      MEM_READY = 1'b0; MEM_RUN_VALID = 1'b1;
      MEM_RUN_BASE = 32'hC0 + 32'(n); MEM_RUN_LEN = 4'd8;
      tick();
      MEM_RUN_VALID = 1'b0;
      for (int i = 0; i < 8; i++) begin
        vec_cnt++;
        if ({GNT_I, GNT_D, RVALID_I, RVALID_D} !== {2'b00, exp_g}) begin
          miss_cnt++;
          $display("FAIL tie_stream n=%0d i=%0d: got %b want %b", n, i, {GNT_I, GNT_D, RVALID_I, RVALID_D}, {2'b00, exp_g});
        end
        vec_cnt++;
        if (RDATA !== 32'hC0 + 32'(n)) begin
          miss_cnt++;
          $display("FAIL tie_rdata n=%0d i=%0d: got %h want %h", n, i, RDATA, 32'hC0 + 32'(n));
        end
        tick();
      end
    end
    REQ_I = 1'b0; REQ_D = 1'b0;
  endtask

  task automatic test_single_load();
    logic [31:0] exp_d [8];
    exp_d = '{32'hA0, 32'hA0, 32'hA0, 32'h55, 32'h55, 32'h55, 32'h55, 32'h55};
    REQ_I = 1'b1; WE_I = 1'b0; ADDR_I = 32'h0000_001D;
    tick();
    vec_cnt++;
    if ({GNT_I, GNT_D, MEM_VALID, MEM_LOAD, MEM_STORE} !== 5'b10110) begin
      miss_cnt++;
      $display("FAIL load_cmd: got %b want 10110", {GNT_I, GNT_D, MEM_VALID, MEM_LOAD, MEM_STORE});
    end
    vec_cnt++;
    if (MEM_ADDR !== 32'h0000_0018) begin
      miss_cnt++;
      $display("FAIL load_addr: got %h want 00000018", MEM_ADDR);
    end
    REQ_I = 1'b0; MEM_READY = 1'b1;
    tick();
    MEM_READY = 1'b0;
    MEM_RUN_VALID = 1'b1; MEM_RUN_BASE = 32'hA0; MEM_RUN_LEN = 4'd3;
    #1;
    vec_cnt++;
    if ({MEM_VALID, MEM_RUN_ACK} !== 2'b01) begin
      miss_cnt++;
      $display("FAIL load_runs_entry: got valid/ack %b want 01", {MEM_VALID, MEM_RUN_ACK});
    end
    tick();
    MEM_RUN_BASE = 32'h55; MEM_RUN_LEN = 4'd5;
    tick();
    MEM_RUN_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vec_cnt++;
      if ({RVALID_I, RVALID_D, DONE_I, RIDX, RDATA} !== {2'b10, (i == 7), 3'(i), exp_d[i]}) begin
        miss_cnt++;
        $display("FAIL load_word i=%0d: got v=%b%b done=%b ridx=%0d data=%h want data=%h", i, RVALID_I, RVALID_D, DONE_I, RIDX, RDATA, exp_d[i]);
      end
      tick();
    end
    vec_cnt++;
    if ({RVALID_I, DONE_I, ERR} !== 3'b000) begin
      miss_cnt++;
      $display("FAIL load_end: got rvalid/done/err %b want 000", {RVALID_I, DONE_I, ERR});
    end
  endtask

  task automatic test_store();
    REQ_D = 1'b1; WE_D = 1'b1; ADDR_D = 32'h0000_0040; WDATA_D = 32'hDEAD_BEEF;
    tick();
    vec_cnt++;
    if ({GNT_I, GNT_D, MEM_VALID, MEM_LOAD, MEM_STORE} !== 5'b01101) begin
      miss_cnt++;
      $display("FAIL store_cmd: got %b want 01101", {GNT_I, GNT_D, MEM_VALID, MEM_LOAD, MEM_STORE});
    end
    vec_cnt++;
    if ({MEM_ADDR, MEM_WDATA} !== {32'h0000_0040, 32'hDEAD_BEEF}) begin
      miss_cnt++;
      $display("FAIL store_bus: got addr=%h wdata=%h want 00000040 deadbeef", MEM_ADDR, MEM_WDATA);
    end
    REQ_D = 1'b0; WE_D = 1'b0;
    tick();
    vec_cnt++;
    if (MEM_VALID !== 1'b1) begin
      miss_cnt++;
      $display("FAIL store_stall: got MEM_VALID=%b want 1", MEM_VALID);
    end
    tick();
    MEM_READY = 1'b1;
    tick();
    MEM_READY = 1'b0;
    vec_cnt++;
    if ({MEM_VALID, MEM_STORE, DONE_D} !== 3'b000) begin
      miss_cnt++;
      $display("FAIL store_write_entry: got %b want 000", {MEM_VALID, MEM_STORE, DONE_D});
    end
    tick();
    tick();
    MEM_WACK = 1'b1;
    vec_cnt++;
    if (DONE_D !== 1'b0) begin
      miss_cnt++;
      $display("FAIL store_early_done: got %b want 0", DONE_D);
    end
    tick();
    MEM_WACK = 1'b0;
    vec_cnt++;
    if ({DONE_I, DONE_D, ERR} !== 3'b010) begin
      miss_cnt++;
      $display("FAIL store_done: got done_i/done_d/err %b want 010", {DONE_I, DONE_D, ERR});
    end
    tick();
    vec_cnt++;
    if (DONE_D !== 1'b0) begin
      miss_cnt++;
      $display("FAIL store_done_pulse: got %b want 0", DONE_D);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] exp_d [8];
    exp_d = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd3, 32'd3};
    REQ_I = 1'b1; WE_I = 1'b0; ADDR_I = 32'h0000_0300;
    tick();
    REQ_I = 1'b0; MEM_READY = 1'b1;
    tick();
    MEM_READY = 1'b0;
    MEM_RUN_VALID = 1'b1; MEM_RUN_BASE = 32'd1; MEM_RUN_LEN = 4'd6;
    tick();
    vec_cnt++;
    if (ERR !== 1'b0) begin
      miss_cnt++;
      $display("FAIL ovr_err_clean: got %b want 0", ERR);
    end
    MEM_RUN_BASE = 32'd2; MEM_RUN_LEN = 4'd0;
    tick();
    vec_cnt++;
    if ({ERR, RVALID_I} !== 2'b10) begin
      miss_cnt++;
      $display("FAIL ovr_err_zero: got err/rvalid %b want 10", {ERR, RVALID_I});
    end
    MEM_RUN_BASE = 32'd3; MEM_RUN_LEN = 4'd5;
    tick();
    MEM_RUN_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vec_cnt++;
      if ({RVALID_I, ERR, DONE_I, RIDX, RDATA} !== {2'b11, (i == 7), 3'(i), exp_d[i]}) begin
        miss_cnt++;
        $display("FAIL ovr_word i=%0d: got v=%b err=%b done=%b ridx=%0d data=%h want data=%h", i, RVALID_I, ERR, DONE_I, RIDX, RDATA, exp_d[i]);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    MEM_RUN_VALID = 1'b1; MEM_RUN_BASE = 32'd9; MEM_RUN_LEN = 4'd8;
    REQ_I = 1'b1; WE_I = 1'b0; ADDR_I = 32'h0000_0500;
    tick();
    vec_cnt++;
    if ({GNT_I, MEM_VALID, ERR, MEM_RUN_ACK} !== 4'b1100) begin
      miss_cnt++;
      $display("FAIL to_cmd: got gnt/valid/err/ack %b want 1100", {GNT_I, MEM_VALID, ERR, MEM_RUN_ACK});
    end
    REQ_I = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if ({DONE_I, MEM_VALID, RVALID_I, MEM_RUN_ACK} !== 4'b0100) begin
        miss_cnt++;
        $display("FAIL to_wait i=%0d: got done/valid/rvalid/ack %b want 0100", i, {DONE_I, MEM_VALID, RVALID_I, MEM_RUN_ACK});
      end
    end
    tick();
    vec_cnt++;
    if ({DONE_I, DONE_D, ERR, MEM_VALID, RVALID_I} !== 5'b10100) begin
      miss_cnt++;
      $display("FAIL to_abort: got done_i/done_d/err/valid/rvalid %b want 10100", {DONE_I, DONE_D, ERR, MEM_VALID, RVALID_I});
    end
    REQ_D = 1'b1; WE_D = 1'b0; ADDR_D = 32'h0000_0700;
    tick();
    vec_cnt++;
    if ({GNT_D, DONE_I, RVALID_I} !== 3'b100) begin
      miss_cnt++;
      $display("FAIL to_idle_regrant: got gnt_d/done_i/rvalid %b want 100", {GNT_D, DONE_I, RVALID_I});
    end
    REQ_D = 1'b0;
    tick();
    tick();
    tick();
    vec_cnt++;
    if (DONE_D !== 1'b0) begin
      miss_cnt++;
      $display("FAIL to_d_early: got %b want 0", DONE_D);
    end
    tick();
    vec_cnt++;
    if ({DONE_D, RVALID_D, MEM_VALID} !== 3'b100) begin
      miss_cnt++;
      $display("FAIL to_d_abort: got done_d/rvalid_d/valid %b want 100", {DONE_D, RVALID_D, MEM_VALID});
    end
    MEM_RUN_VALID = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    REQ_I = 1'b1; WE_I = 1'b0; ADDR_I = 32'h0000_0600;
    tick();
    REQ_I = 1'b0; MEM_READY = 1'b1;
    tick();
    MEM_READY = 1'b0;
    MEM_RUN_VALID = 1'b1; MEM_RUN_BASE = 32'd7; MEM_RUN_LEN = 4'd8;
    tick();
    MEM_RUN_VALID = 1'b0;
    tick();
    tick();
    tick();
    vec_cnt++;
    if ({RVALID_I, RIDX, RDATA} !== {1'b1, 3'd3, 32'd7}) begin
      miss_cnt++;
      $display("FAIL rst_pre: got rvalid=%b ridx=%0d data=%h want 1 3 7", RVALID_I, RIDX, RDATA);
    end
    RESET = 1'b1;
    tick();
    vec_cnt++;
    if ({RVALID_I, RVALID_D, DONE_I, DONE_D, ERR, MEM_VALID, MEM_LOAD, MEM_STORE, MEM_RUN_ACK} !== 9'd0) begin
      miss_cnt++;
      $display("FAIL rst_flags: got %b want 0", {RVALID_I, RVALID_D, DONE_I, DONE_D, ERR, MEM_VALID, MEM_LOAD, MEM_STORE, MEM_RUN_ACK});
    end
    vec_cnt++;
    if ({RIDX, RDATA, MEM_ADDR, MEM_WDATA} !== 99'd0) begin
      miss_cnt++;
      $display("FAIL rst_buses: got ridx=%0d rdata=%h addr=%h wdata=%h want 0", RIDX, RDATA, MEM_ADDR, MEM_WDATA);
    end
    RESET = 1'b0;
    REQ_I = 1'b1; REQ_D = 1'b1;
    tick();
    vec_cnt++;
    if ({GNT_I, GNT_D} !== 2'b10) begin
      miss_cnt++;
      $display("FAIL rst_tie: got %b want 10", {GNT_I, GNT_D});
    end
    REQ_I = 1'b0; REQ_D = 1'b0;
    tick();
  endtask

  initial begin
    RESET = 1'b1;
    REQ_I = 1'b0; REQ_D = 1'b0; WE_I = 1'b0; WE_D = 1'b0;
    ADDR_I = 32'd0; ADDR_D = 32'd0; WDATA_I = 32'd0; WDATA_D = 32'd0;
    MEM_READY = 1'b0; MEM_RUN_VALID = 1'b0; MEM_RUN_BASE = 32'd0;
    MEM_RUN_LEN = 4'd0; MEM_WACK = 1'b0;
    test_reset();
    test_tie_rr();
    test_single_load();
    test_store();
    test_overrun();
    test_timeout();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
